// File: rtl/perifericos_pkg.sv
// Shared default constants for the push-button debouncer.
// These set the debounce threshold and the synchronizer depth.
package perifericos_pkg;

    localparam int DEF_STABLE_COUNT = 10;
    localparam int DEF_SYNC_STAGES  = 2;

endpackage

// File: rtl/perifericos_sync_ff.sv
// Multi-stage flip-flop synchronizer that brings an asynchronous level into the clk domain.
// All stages clear to 0 on a synchronous, active-high reset.
module sync_ff
    import perifericos_pkg::*;
#(
    parameter int DEPTH = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/perifericos.sv
// Push-button debouncer: synchronizes the raw level, then moves btn_out only after
// the synchronized level has disagreed with it for STABLE_COUNT consecutive cycles.
module perifericos
    import perifericos_pkg::*;
#(
    parameter int STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_out
);

    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

    logic          btn_sync;
    logic [CW-1:0] count;

    sync_ff #(
        .DEPTH(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_in),
        .q    (btn_sync)
    );

    // Any cycle of agreement restarts the count, so only an unbroken run can flip btn_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            btn_out <= 1'b0;
        end else if (btn_sync == btn_out) begin
            count <= '0;
        end else if (count == LAST) begin
            count   <= '0;
            btn_out <= btn_sync;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_perifericos.sv
// Directed bench for the debouncer: the driver queues the expected btn_out per cycle,
// and an independent monitor compares it shortly after each rising edge.
`timescale 1us/1ns
module tb_perifericos;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_in = 1'b0;
    logic btn_out;

    int compared = 0;
    int mismatched = 0;
    logic [0:0] exp_q[$];
    string tag_q[$];
    string scen = "init";

    // 500 us period
    always #250 clk = ~clk;

    perifericos dut (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_in),
        .btn_out(btn_out)
    );

    // One vector per cycle; e is btn_out expected right after the next rising edge.
    task automatic drive(input logic r, input logic b, input logic e);
        @(negedge clk);
        reset  = r;
        btn_in = b;
        exp_q.push_back(e);
        tag_q.push_back(scen);
    endtask

    task automatic run_pulse(input string name, input int len, input int rise_at,
                             input int fall_at, input int total);
        scen = name;
        for (int i = 1; i <= total; i++) begin
            drive(1'b0, (i <= len), (i >= rise_at && i < fall_at));
        end
    endtask

    always @(posedge clk) begin
        logic [0:0] e;
        string t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            compared++;
            if (btn_out !== e[0]) begin
                mismatched++;
                $display("FAIL %s at %0t: btn_out=%b expected %b", t, $time, btn_out, e[0]);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0",
                 exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for one cycle, then idle low for 2 ms.
        scen = "reset_idle";
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);

        // Clean 20-cycle press: rise at edge 12, release at vector 21 -> fall at edge 32.
        run_pulse("press20", 20, 12, 32, 50);
        // Short presses never reach the threshold.
        run_pulse("press6", 6, 0, 0, 30);
        run_pulse("press9", 9, 0, 0, 30);
        // Exactly at threshold: rise at 12, fall at 22.
        run_pulse("press10", 10, 12, 22, 35);

        // Bounce 1,0,1,0... for 8 cycles, hold 1 from vector 9 to 28, then release.
        scen = "bounce";
        for (int i = 1; i <= 60; i++) begin
            drive(1'b0, (i <= 8) ? (i % 2 == 1) : (i <= 28), (i >= 20 && i < 40));
        end

        // Held press, reset applied when the count reaches 7; full latency after release.
        scen = "reset_mid";
        for (int i = 1; i <= 60; i++) begin
            drive((i == 10), (i <= 40), (i >= 22 && i < 52));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: queue depth %0d expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
